fp_exec_controller: RTL

//  Issue/sequencing controller for the RV32F FP execute stage. Accepts one FP op per handshake from decode.

---
 rtl/fp_exec_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_exec_controller.sv
// Issue/sequencing controller for the RV32F FP execute stage: holds the op for its latency, captures the result and accumulates fflags.
// Optional FP_EXEC_OPGATE_EN: gate ex_enable and isolate ex_rs* operands outside EXEC.
module fp_exec_controller #(
    parameter logic [4:0]  DIV_OP  = 5'h03,
    parameter logic [4:0]  SQRT_OP = 5'h0B,
    parameter logic [4:0]  MUL_OP  = 5'h02,
    parameter int unsigned DIV_LAT = 12,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_op,
    input  logic [2:0]  issue_rm,
    input  logic        issue_i2f,
    input  logic        issue_f2i,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,
    input  logic [31:0] issue_rs3,
    input  logic [31:0] issue_int_rs1,
    input  logic [2:0]  frm,
    input  logic        flush,
    output logic [31:0] ex_rs1,
    output logic [31:0] ex_rs2,
    output logic [31:0] ex_rs3,
    output logic [31:0] ex_int_rs1,
    output logic [4:0]  ex_op,
    output logic [2:0]  ex_rm,
    output logic        ex_i2f,
    output logic        ex_f2i,
    output logic        ex_enable,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_fflags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_fflags,
    output logic [4:0]  wb_rd,
    output logic        wb_illegal,
    output logic [4:0]  fflags_acc,
    input  logic        fflags_clr,
    output logic        busy
);
    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, int_rs1_q, int_rs1_d;
    logic [4:0]        op_q, op_d;
    logic [2:0]        rm_q, rm_d;
    logic              i2f_q, i2f_d, f2i_q, f2i_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       wb_result_q, wb_result_d;
    logic [4:0]        wb_fflags_q, wb_fflags_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_illegal_q, wb_illegal_d;
    logic [4:0]        fflags_acc_q, fflags_acc_d;
    logic [2:0]        rm_res;
    logic              rm_illegal, fire_i, fire_w;
    logic [CNT_W-1:0]  lat_init;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rs3_d        = rs3_q;
        int_rs1_d    = int_rs1_q;
        op_d         = op_q;
        rm_d         = rm_q;
        i2f_d        = i2f_q;
        f2i_d        = f2i_q;
        rd_d         = rd_q;
        wb_result_d  = wb_result_q;
        wb_fflags_d  = wb_fflags_q;
        wb_rd_d      = wb_rd_q;
        wb_illegal_d = wb_illegal_q;

        rm_res      = (issue_rm == 3'b111) ? frm : issue_rm;
        rm_illegal  = (rm_res >= 3'b101);
        issue_ready = !flush && ((state_q == IDLE) || ((state_q == WB) && wb_ready));
        fire_i      = issue_valid && issue_ready;
        // A flushed writeback is dropped, so its flags must not reach fcsr.
        fire_w      = (state_q == WB) && wb_ready && !flush;

        if ((issue_op == DIV_OP) || (issue_op == SQRT_OP)) lat_init = CNT_W'(DIV_LAT - 1);
        else if (issue_op == MUL_OP)                        lat_init = CNT_W'(MUL_LAT - 1);
        else                                                lat_init = '0;

        fflags_acc_d = (fflags_clr ? 5'b0 : fflags_acc_q)
                     | ((fire_w && !wb_illegal_q) ? wb_fflags_q : 5'b0);

        case (state_q)
            EXEC: begin
                if (cnt_q == '0) begin
                    wb_result_d  = ex_result;
                    wb_fflags_d  = ex_fflags;
                    wb_rd_d      = rd_q;
                    wb_illegal_d = 1'b0;
                    state_d      = WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB:      if (fire_w) state_d = IDLE;
            default: ;
        endcase

        if (fire_i) begin
            rs1_d     = issue_rs1;
            rs2_d     = issue_rs2;
            rs3_d     = issue_rs3;
            int_rs1_d = issue_int_rs1;
            op_d      = issue_op;
            rm_d      = rm_res;
            i2f_d     = issue_i2f;
            f2i_d     = issue_f2i;
            rd_d      = issue_rd;
            // Illegal rounding mode bypasses execution and reports straight to writeback.
            if (rm_illegal) begin
                state_d      = WB;
                cnt_d        = '0;
                wb_result_d  = 32'b0;
                wb_fflags_d  = 5'b0;
                wb_rd_d      = issue_rd;
                wb_illegal_d = 1'b1;
            end else begin
                state_d = EXEC;
                cnt_d   = lat_init;
            end
        end

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs3_q        <= '0;
            int_rs1_q    <= '0;
            op_q         <= '0;
            rm_q         <= '0;
            i2f_q        <= 1'b0;
            f2i_q        <= 1'b0;
            rd_q         <= '0;
            wb_result_q  <= '0;
            wb_fflags_q  <= '0;
            wb_rd_q      <= '0;
            wb_illegal_q <= 1'b0;
            fflags_acc_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rs3_q        <= rs3_d;
            int_rs1_q    <= int_rs1_d;
            op_q         <= op_d;
            rm_q         <= rm_d;
            i2f_q        <= i2f_d;
            f2i_q        <= f2i_d;
            rd_q         <= rd_d;
            wb_result_q  <= wb_result_d;
            wb_fflags_q  <= wb_fflags_d;
            wb_rd_q      <= wb_rd_d;
            wb_illegal_q <= wb_illegal_d;
            fflags_acc_q <= fflags_acc_d;
        end
    end

`ifdef FP_EXEC_OPGATE_EN
    assign ex_enable  = (state_q == EXEC);
    assign ex_rs1     = (state_q == EXEC) ? rs1_q     : 32'b0;
    assign ex_rs2     = (state_q == EXEC) ? rs2_q     : 32'b0;
    assign ex_rs3     = (state_q == EXEC) ? rs3_q     : 32'b0;
    assign ex_int_rs1 = (state_q == EXEC) ? int_rs1_q : 32'b0;
`else
    assign ex_enable  = 1'b1;
    assign ex_rs1     = rs1_q;
    assign ex_rs2     = rs2_q;
    assign ex_rs3     = rs3_q;
    assign ex_int_rs1 = int_rs1_q;
`endif

    assign ex_op      = op_q;
    assign ex_rm      = rm_q;
    assign ex_i2f     = i2f_q;
    assign ex_f2i     = f2i_q;
    assign wb_valid   = (state_q == WB);
    assign wb_result  = wb_result_q;
    assign wb_fflags  = wb_fflags_q;
    assign wb_rd      = wb_rd_q;
    assign wb_illegal = wb_illegal_q;
    assign fflags_acc = fflags_acc_q;
    assign busy       = (state_q != IDLE);
endmodule
